matrix_key_scan: RTL and testbench
==================================

MATRIX_KEY_SCAN -- requirements
Module: matrix_key_scan

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 10000000, system clock frequency in Hz.
REQ-002 SHALL have parameter STEP_FREQ, default 1000, column-step tick rate in Hz.
REQ-003 SHALL have parameter DEB_STEPS, default 20, consecutive stable ticks required for press or release.
REQ-004 SHALL have parameter RPT_DELAY, default 500, ticks held before the first auto-repeat.
REQ-005 SHALL have parameter RPT_PERIOD, default 100, ticks between later auto-repeats.
REQ-006 SHALL have port clk  input  1  system clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port col_drv  output  4  keypad column drive, active-low one-hot.
REQ-009 SHALL have port row_in  input  4  keypad row sense, externally pulled up; low means pressed.
REQ-010 SHALL have port key_code  output  4  code of the last accepted key, row*4+col.
REQ-011 SHALL have port key_valid  output  1  one-clk pulse per accepted press or repeat.
REQ-012 SHALL have port key_down  output  1  level; high while the accepted key is held.

Function
REQ-013 SHALL synchronise row_in through two flops (row_s) before any use.
REQ-014 SHALL generate a one-clk tick when the 32-bit divider equals CLK_FREQ/STEP_FREQ-1; the divider then returns to 0.
REQ-015 SHALL implement states SCAN, DEBOUNCE, HELD; all transitions occur only on tick.
REQ-016 SCAN: col_drv = ~(1<<col_idx); on tick, if row_s != 4'hF, capture col_idx and the lowest-index low row, clear deb_cnt, go to DEBOUNCE; otherwise col_idx increments, wrapping 3->0.
REQ-017 DEBOUNCE: col_idx is frozen; on tick, if the captured row is low, deb_cnt increments; when it reaches DEB_STEPS, go to HELD, load key_code, pulse key_valid.
REQ-018 DEBOUNCE: on tick, if the captured row is high, return to SCAN with col_idx+1 and no key_valid.
REQ-019 HELD: key_down=1; column is frozen; rel_cnt increments on each tick with the captured row high and clears on a tick with it low.
REQ-020 HELD: when rel_cnt reaches DEB_STEPS, go to SCAN, drop key_down, advance col_idx, and leave key_code unchanged.
REQ-021 Other keys pressed while in DEBOUNCE or HELD SHALL be ignored; the first key found in scan order wins.
REQ-022 key_valid SHALL be high in exactly the clk cycle after the qualifying tick and never for two consecutive cycles.

Reset
REQ-023 rst_n low SHALL asynchronously set state=SCAN, col_idx=0, col_drv=4'b1110, key_code=0, key_valid=0, key_down=0, and clear all counters and synchroniser flops to their idle values (synchroniser to 1).
REQ-024 Reset asserted mid-DEBOUNCE or mid-HELD SHALL drop key_valid and key_down immediately, with no pulse on release of reset.

Configuration
REQ-025 With macro KEY_REPEAT_EN defined: in HELD, a rpt_cnt counts ticks while the captured row is low; the first key_valid pulse (same key_code) occurs at RPT_DELAY ticks, then every RPT_PERIOD ticks until release.
REQ-026 Without KEY_REPEAT_EN: no repeat logic is present, and exactly one key_valid is produced per press.

Verification
Bench parameters: CLK_FREQ=1000, STEP_FREQ=100 (tick every 10 clk), DEB_STEPS=3, RPT_DELAY=8, RPT_PERIOD=4.
REQ-027 Reset then idle rows=4'hF for 80 clk -> col_drv cycles 1110,1101,1011,0111,1110 at 10-clk steps; key_valid stays 0.
REQ-028 Hold row1 low while col2 is driven, for 60 clk -> key_code=6, a single key_valid pulse after the 3rd stable tick, key_down=1; release -> key_down=0 after 3 high ticks.
REQ-029 Row low for only 1 tick (bounce) -> no key_valid, and scanning resumes at the next column.
REQ-030 Key 6 held, then row2 also goes low on col2 -> key_code stays 6 with no extra pulse.
REQ-031 rst_n pulsed low during HELD -> key_down=0 and col_drv=1110 within the same cycle, asynchronously.
REQ-032 KEY_REPEAT_EN build, key 0 held 20 ticks -> pulses at acceptance and at +8, +12, +16, +20 ticks; non-repeat build -> one pulse only.

Source files
------------

// File: rtl/matrix_key_scan_if.sv
// Keypad-side bundle for matrix_key_scan: column drive, row sense and the
// decoded key outputs. The scanner uses the master view; a keypad model uses slave.
interface matrix_key_scan_if;
  logic [3:0] col_drv;
  logic [3:0] row_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (output col_drv, key_code, key_valid, key_down, input row_in);
  modport slave  (input col_drv, key_code, key_valid, key_down, output row_in);
endinterface

// File: rtl/matrix_key_scan.sv
// 4x4 matrix keypad scanner with tick-based debounce and press/release hysteresis.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module matrix_key_scan #(
  parameter int CLK_FREQ   = 10000000,
  parameter int STEP_FREQ  = 1000,
  parameter int DEB_STEPS  = 20,
  parameter int RPT_DELAY  = 500,
  parameter int RPT_PERIOD = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_key_scan_if.master  bus
);

  localparam logic [31:0] DIV_MAX = 32'(CLK_FREQ / STEP_FREQ - 1);
  // One width serves every tick counter so the repeat build needs no extra sizing.
  localparam int CNT_MAX_A = (DEB_STEPS > RPT_DELAY) ? DEB_STEPS : RPT_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > RPT_PERIOD) ? CNT_MAX_A : RPT_PERIOD;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEB_STEPS);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2} state_t;

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0])      low_row = 2'd0;
    else if (!rows[1]) low_row = 2'd1;
    else if (!rows[2]) low_row = 2'd2;
    else               low_row = 2'd3;
  endfunction

  logic [3:0]       row_meta_r, row_sync_r;
  logic [31:0]      div_r;
  logic             tick_s, row_low_s;
  state_t           state_r, state_nxt;
  logic [1:0]       col_idx_r, col_nxt, row_idx_r, row_nxt;
  logic [CNT_W-1:0] deb_cnt_r, deb_nxt, rel_cnt_r, rel_nxt;
  logic [3:0]       key_code_r, code_nxt, col_drv_r, col_drv_nxt;
  logic             key_valid_r, valid_nxt, key_down_r, down_nxt;
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(RPT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(RPT_PERIOD);
  logic [CNT_W-1:0] rpt_cnt_r, rpt_nxt, rpt_sum_s;
  logic             rpt_first_r, first_nxt;
`endif

  assign tick_s    = (div_r == DIV_MAX);
  assign row_low_s = ~row_sync_r[row_idx_r];

  // Two-flop synchroniser for the asynchronous row lines (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= bus.row_in;
      row_sync_r <= row_meta_r;
    end
  end

  // Step divider producing the one-clock scan tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_r <= 32'd0;
    else if (tick_s) div_r <= 32'd0;
    else             div_r <= div_r + 32'd1;
  end

  // Next-state and output decode; nothing moves except on a tick.
  always_comb begin
    state_nxt = state_r;
    col_nxt   = col_idx_r;
    row_nxt   = row_idx_r;
    deb_nxt   = deb_cnt_r;
    rel_nxt   = rel_cnt_r;
    code_nxt  = key_code_r;
    valid_nxt = 1'b0;
    down_nxt  = key_down_r;
`ifdef KEY_REPEAT_EN
    rpt_nxt   = rpt_cnt_r;
    first_nxt = rpt_first_r;
    rpt_sum_s = rpt_cnt_r + CNT_ONE;
`endif
    if (tick_s) begin
      case (state_r)
        SCAN: begin
          if (row_sync_r != 4'hF) begin
            state_nxt = DEBOUNCE;
            row_nxt   = low_row(row_sync_r);
            deb_nxt   = CNT_ZERO;
          end else begin
            col_nxt = col_idx_r + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_low_s) begin
            if (deb_cnt_r + CNT_ONE == DEB_LIM) begin
              state_nxt = HELD;
              code_nxt  = {row_idx_r, col_idx_r};
              valid_nxt = 1'b1;
              down_nxt  = 1'b1;
              rel_nxt   = CNT_ZERO;
`ifdef KEY_REPEAT_EN
              rpt_nxt   = CNT_ZERO;
              first_nxt = 1'b1;
`endif
            end else begin
              deb_nxt = deb_cnt_r + CNT_ONE;
            end
          end else begin
            state_nxt = SCAN;
            col_nxt   = col_idx_r + 2'd1;
          end
        end
        HELD: begin
          if (row_low_s) begin
            rel_nxt = CNT_ZERO;
`ifdef KEY_REPEAT_EN
            if (rpt_sum_s == (rpt_first_r ? RPT_DLY : RPT_PER)) begin
              valid_nxt = 1'b1;
              rpt_nxt   = CNT_ZERO;
              first_nxt = 1'b0;
            end else begin
              rpt_nxt = rpt_sum_s;
            end
`endif
          end else if (rel_cnt_r + CNT_ONE == DEB_LIM) begin
            state_nxt = SCAN;
            down_nxt  = 1'b0;
            rel_nxt   = CNT_ZERO;
            col_nxt   = col_idx_r + 2'd1;
          end else begin
            rel_nxt = rel_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt = SCAN;
          down_nxt  = 1'b0;
        end
      endcase
    end else begin
      valid_nxt = 1'b0;
    end
    col_drv_nxt = ~(4'b0001 << col_nxt);
  end

  // Scanner state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SCAN;
      col_idx_r   <= 2'd0;
      row_idx_r   <= 2'd0;
      deb_cnt_r   <= CNT_ZERO;
      rel_cnt_r   <= CNT_ZERO;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_down_r  <= 1'b0;
      col_drv_r   <= 4'b1110;
`ifdef KEY_REPEAT_EN
      rpt_cnt_r   <= CNT_ZERO;
      rpt_first_r <= 1'b1;
`endif
    end else begin
      state_r     <= state_nxt;
      col_idx_r   <= col_nxt;
      row_idx_r   <= row_nxt;
      deb_cnt_r   <= deb_nxt;
      rel_cnt_r   <= rel_nxt;
      key_code_r  <= code_nxt;
      key_valid_r <= valid_nxt;
      key_down_r  <= down_nxt;
      col_drv_r   <= col_drv_nxt;
`ifdef KEY_REPEAT_EN
      rpt_cnt_r   <= rpt_nxt;
      rpt_first_r <= first_nxt;
`endif
    end
  end

  assign bus.col_drv   = col_drv_r;
  assign bus.key_code  = key_code_r;
  assign bus.key_valid = key_valid_r;
  assign bus.key_down  = key_down_r;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Self-checking bench for matrix_key_scan: keypad model, key_valid scoreboard,
// a table of single-key presses and hand-written bounce/ignore/reset/repeat sequences.
module tb_matrix_key_scan;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] keys = 16'h0000;
  logic [3:0]  row_v;
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  matrix_key_scan_if kif();

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.col_drv[c]) row_v[r] = 1'b0;
  end
  assign kif.row_in = row_v;

  matrix_key_scan #(
    .CLK_FREQ(1000), .STEP_FREQ(100), .DEB_STEPS(3), .RPT_DELAY(8), .RPT_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(kif.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_down(input logic lvl, input int max_clk, input string name);
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (kif.key_down == lvl) break;
    end
    check(name, 32'(kif.key_down), 32'(lvl));
  endtask

  task automatic wait_col(input logic [3:0] pat, input int max_clk, input string name);
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (kif.col_drv != pat) break;
    end
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (kif.col_drv == pat) break;
    end
    check(name, 32'(kif.col_drv), 32'(pat));
  endtask

  // Scoreboard: every key_valid pulse pops one expected code.
  initial begin
    forever begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        pulse_cnt++;
        check("no_back_to_back", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got code %0h expected no pulse", kif.key_code);
        end else begin
          check("pulse_code", 32'(kif.key_code), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = kif.key_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[6];
    logic [3:0] sweep[5];
    int         p0;
    int         n_rpt;

    tbl[0] = '{keys: 16'h0040, code: 4'd6,  name: "key6"};
    tbl[1] = '{keys: 16'h0001, code: 4'd0,  name: "key0"};
    tbl[2] = '{keys: 16'h8000, code: 4'd15, name: "key15"};
    tbl[3] = '{keys: 16'h0200, code: 4'd9,  name: "key9"};
    tbl[4] = '{keys: 16'h0008, code: 4'd3,  name: "key3"};
    tbl[5] = '{keys: 16'h0220, code: 4'd5,  name: "lowest_row_5v9"};
    sweep[0] = 4'b1110; sweep[1] = 4'b1101; sweep[2] = 4'b1011;
    sweep[3] = 4'b0111; sweep[4] = 4'b1110;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_drv",   32'(kif.col_drv),   32'(4'b1110));
    check("rst_key_code",  32'(kif.key_code),  32'd0);
    check("rst_key_valid", 32'(kif.key_valid), 32'd0);
    check("rst_key_down",  32'(kif.key_down),  32'd0);
    rst_n = 1'b1;

    // Idle column sweep, sampled mid-step.
    p0 = pulse_cnt;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat (10) @(negedge clk);
      check($sformatf("sweep_%0d", i), 32'(kif.col_drv), 32'(sweep[i]));
    end
    repeat (35) @(negedge clk);
    check("idle_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    // Table of single presses: accept, hold briefly, release.
    for (int i = 0; i < 6; i++) begin
      p0 = pulse_cnt;
      exp_q.push_back(tbl[i].code);
      keys = tbl[i].keys;
      wait_down(1'b1, 150, {tbl[i].name, "_down_rise"});
      check({tbl[i].name, "_code"}, 32'(kif.key_code), 32'(tbl[i].code));
      repeat (40) @(negedge clk);
      check({tbl[i].name, "_held"}, 32'(kif.key_down), 32'd1);
      keys = 16'h0000;
      wait_down(1'b0, 100, {tbl[i].name, "_down_fall"});
      check({tbl[i].name, "_code_kept"}, 32'(kif.key_code), 32'(tbl[i].code));
      check({tbl[i].name, "_one_pulse"}, 32'(pulse_cnt - p0), 32'd1);
      repeat (20) @(negedge clk);
    end

    // Bounce: row low for a single tick on column 1.
    p0 = pulse_cnt;
    wait_col(4'b1101, 60, "bounce_col1");
    keys = 16'h0002;
    repeat (14) @(negedge clk);
    keys = 16'h0000;
    repeat (10) @(negedge clk);
    check("bounce_next_col", 32'(kif.col_drv), 32'(4'b1011));
    check("bounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("bounce_no_down", 32'(kif.key_down), 32'd0);

    // Second key on the held column is ignored.
    p0 = pulse_cnt;
    exp_q.push_back(4'd6);
    keys = 16'h0040;
    wait_down(1'b1, 150, "ignore_down_rise");
    keys = 16'h0440;
    repeat (60) @(negedge clk);
    check("ignore_code", 32'(kif.key_code), 32'd6);
    check("ignore_one_pulse", 32'(pulse_cnt - p0), 32'd1);
    check("ignore_still_down", 32'(kif.key_down), 32'd1);
    keys = 16'h0000;
    wait_down(1'b0, 100, "ignore_down_fall");
    repeat (20) @(negedge clk);

    // Asynchronous reset while HELD.
    p0 = pulse_cnt;
    exp_q.push_back(4'd6);
    keys = 16'h0040;
    wait_down(1'b1, 150, "rst_held_rise");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_down",  32'(kif.key_down),  32'd0);
    check("async_rst_col",   32'(kif.col_drv),   32'(4'b1110));
    check("async_rst_valid", 32'(kif.key_valid), 32'd0);
    keys = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_no_new_pulse", 32'(pulse_cnt - p0), 32'd1);
    check("rst_down_low", 32'(kif.key_down), 32'd0);

    // Long hold of key 0: auto-repeat only in the repeat build.
`ifdef KEY_REPEAT_EN
    n_rpt = 5;
`else
    n_rpt = 1;
`endif
    p0 = pulse_cnt;
    for (int i = 0; i < n_rpt; i++) exp_q.push_back(4'd0);
    keys = 16'h0001;
    wait_down(1'b1, 150, "rpt_down_rise");
    repeat (205) @(negedge clk);
    keys = 16'h0000;
    wait_down(1'b0, 100, "rpt_down_fall");
    check("rpt_pulse_count", 32'(pulse_cnt - p0), 32'(n_rpt));

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
